load_store_unit: RTL

Initiator side of the data-memory interface: the block between the core's execute stage and the word-organised data memory. It accepts byte/halfword/word load and store requests, drives the memory's `MemRead`/`MemWrite`/address/write-data pins, and returns aligned, extended load data. Sub-word stores use read-modify-write, because the memory only stores whole 32-bit words.

---
 rtl/load_store_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word requests into whole-word memory accesses.
// Sub-word stores use read-modify-write. Loads come back aligned and extended.
module load_store_unit #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              write_q;
    logic              err_q;
    logic [15:0]       wdata_q;
    logic [31:0]       buf_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic              req_err;
    logic              accept;
    logic [31:0]       merged;
    logic [31:0]       load_data;

    assign req_err = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign accept  = (state_q == StIdle) && req_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_write && req_size == 2'b10) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:  state_d = write_q ? StWrite : StResp;
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Merge the sub-word store data into the word currently on mem_rdata.
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00) begin
            unique case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        h = 16'h0000;
        unique case (lane_q)
            2'd0: b = buf_q[7:0];
            2'd1: b = buf_q[15:8];
            2'd2: b = buf_q[23:16];
            2'd3: b = buf_q[31:24];
            default: b = 8'h00;
        endcase
        h = lane_q[1] ? buf_q[31:16] : buf_q[15:0];
        unique case (size_q)
            2'b00:   load_data = {{24{signed_q & b[7]}}, b};
            2'b01:   load_data = {{16{signed_q & h[15]}}, h};
            default: load_data = buf_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= 16'h0000;
            buf_q       <= 32'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lane_q   <= req_addr[1:0];
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
                err_q    <= req_err;
                wdata_q  <= req_wdata[15:0];
                // Memory pins only move when a strobe is about to be issued.
                if (!req_err) begin
                    mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                    if (req_write && req_size == 2'b10) begin
                        mem_wdata_q <= req_wdata;
                    end
                end
            end
            if (state_q == StRead) begin
                buf_q <= mem_rdata;
                if (write_q) begin
                    mem_wdata_q <= merged;
                end
            end
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign MemRead    = (state_q == StRead);
    assign MemWrite   = (state_q == StWrite);
    assign resp_valid = (state_q == StResp);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !write_q) ? load_data : 32'h0;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
